// File: rtl/counter_ud.sv
// Up/down modulo counter with clamped parallel load, boundary pulse and sticky overflow.
// Define COUNTER_UD_SAT_EN to saturate at the boundaries instead of wrapping.
module counter_ud #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             OVF_CLR,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             TC,
    output logic             OVF
);

    // Arithmetic is done one bit wider so compares and increments never truncate.
    localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX};

    logic [WIDTH-1:0] o_q, o_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   d_ext;

    assign count_ext = {1'b0, o_q};
    assign d_ext     = {1'b0, D};

    always_comb begin
        o_d    = o_q;
        cout_d = 1'b0;
        ovf_d  = ovf_q;
        if (OVF_CLR) begin
            ovf_d = 1'b0;
        end
        if (LD) begin
            o_d = (d_ext > MAX_EXT) ? MAX : D;
        end else if (CE) begin
            if (UP) begin
                if (count_ext < MAX_EXT) begin
                    o_d = WIDTH'(count_ext + 1'b1);
                end else begin
                    // A boundary event sets OVF even when OVF_CLR is asserted on the same edge.
                    ovf_d = 1'b1;
`ifdef COUNTER_UD_SAT_EN
                    o_d    = MAX;
`else
                    o_d    = '0;
                    cout_d = 1'b1;
`endif
                end
            end else begin
                if (count_ext != '0) begin
                    o_d = WIDTH'(count_ext - 1'b1);
                end else begin
                    ovf_d = 1'b1;
`ifdef COUNTER_UD_SAT_EN
                    o_d    = '0;
`else
                    o_d    = MAX;
                    cout_d = 1'b1;
`endif
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            o_q    <= INIT;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            o_q    <= o_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign O    = o_q;
    assign COUT = cout_q;
    assign OVF  = ovf_q;
    assign TC   = UP ? (o_q == MAX) : (o_q == '0);

endmodule

// File: tb/tb_counter_ud.sv
// Directed table-driven bench for counter_ud with WIDTH=4, MAX=9, INIT=0.
module tb_counter_ud;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, ce, up, ld, ovf_clr;
    logic [W-1:0] d;
    logic [W-1:0] o;
    logic         cout, tc, ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         reset;
        logic         ce;
        logic         up;
        logic         ld;
        logic         ovf_clr;
        logic [W-1:0] d;
        logic [W-1:0] o;
        logic         cout;
        logic         ovf;
        logic         tc;
    } vec_t;

    vec_t vecs[$];

    counter_ud #(.WIDTH(4), .MAX(4'd9), .INIT(4'd0)) dut (
        .CLK(clk), .RESET(reset), .CE(ce), .UP(up), .LD(ld), .D(d),
        .OVF_CLR(ovf_clr), .O(o), .COUT(cout), .TC(tc), .OVF(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic c, input logic u, input logic l,
                                input logic clr, input logic [W-1:0] dv, input logic [W-1:0] eo,
                                input logic ec, input logic ev, input logic et);
        vec_t v;
        v.reset = r; v.ce = c; v.up = u; v.ld = l; v.ovf_clr = clr; v.d = dv;
        v.o = eo; v.cout = ec; v.ovf = ev; v.tc = et;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic c, input logic u, input logic l,
                         input logic clr, input logic [W-1:0] dv);
        @(negedge clk);
        reset = r; ce = c; up = u; ld = l; ovf_clr = clr; d = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v.reset, v.ce, v.up, v.ld, v.ovf_clr, v.d);
        chk($sformatf("v%0d_o", idx), 32'(o), 32'(v.o));
        chk($sformatf("v%0d_cout", idx), 32'(cout), 32'(v.cout));
        chk($sformatf("v%0d_ovf", idx), 32'(ovf), 32'(v.ovf));
        chk($sformatf("v%0d_tc", idx), 32'(tc), 32'(v.tc));
    endtask

    initial begin
        reset = 1'b0; ce = 1'b0; up = 1'b1; ld = 1'b0; ovf_clr = 1'b0; d = '0;

        //  rst ce up ld clr  d     o    cout ovf tc
        add(1, 0, 1, 0, 0, 4'd0,  4'd0, 0, 0, 0);
`ifndef COUNTER_UD_SAT_EN
        for (int i = 1; i <= 9; i++)
            add(0, 1, 1, 0, 0, 4'd0, 4'(i), 0, 0, (i == 9));
        add(0, 1, 1, 0, 0, 4'd0,  4'd0, 1, 1, 0);
        add(0, 1, 1, 0, 0, 4'd0,  4'd1, 0, 1, 0);
        add(0, 1, 1, 0, 0, 4'd0,  4'd2, 0, 1, 0);
        // load 3 then count down through the 0 -> 9 wrap
        add(0, 0, 0, 1, 0, 4'd3,  4'd3, 0, 1, 0);
        add(0, 1, 0, 0, 0, 4'd0,  4'd2, 0, 1, 0);
        add(0, 1, 0, 0, 0, 4'd0,  4'd1, 0, 1, 0);
        add(0, 1, 0, 0, 0, 4'd0,  4'd0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 4'd0,  4'd9, 1, 1, 0);
        add(0, 1, 0, 0, 0, 4'd0,  4'd8, 0, 1, 0);
        // OVF_CLR coinciding with a wrap keeps OVF, alone it clears
        add(0, 1, 1, 0, 0, 4'd0,  4'd9, 0, 1, 1);
        add(0, 1, 1, 0, 1, 4'd0,  4'd0, 1, 1, 0);
        add(0, 0, 1, 0, 1, 4'd0,  4'd0, 0, 0, 0);
        // clamp load, load beats count, hold
        add(0, 0, 1, 1, 0, 4'd14, 4'd9, 0, 0, 1);
        add(0, 1, 1, 1, 0, 4'd5,  4'd5, 0, 0, 0);
        add(0, 0, 0, 0, 0, 4'd2,  4'd5, 0, 0, 0);
        // back-to-back boundary events keep COUT high
        add(0, 0, 0, 1, 0, 4'd0,  4'd0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 4'd0,  4'd9, 1, 1, 0);
        add(0, 1, 1, 0, 0, 4'd0,  4'd0, 1, 1, 0);
        // reset overrides count at O=7, then counting resumes
        add(0, 0, 1, 1, 0, 4'd7,  4'd7, 0, 1, 0);
        add(1, 1, 1, 0, 0, 4'd0,  4'd0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 4'd0,  4'd1, 0, 0, 0);
        // reset aborts a pending wrap pulse
        add(0, 0, 1, 1, 0, 4'd9,  4'd9, 0, 0, 1);
        add(1, 1, 1, 0, 1, 4'd0,  4'd0, 0, 0, 0);
`else
        add(0, 0, 1, 1, 0, 4'd9,  4'd9, 0, 0, 1);
        add(0, 1, 1, 0, 0, 4'd0,  4'd9, 0, 1, 1);
        add(0, 1, 1, 0, 0, 4'd0,  4'd9, 0, 1, 1);
        add(0, 1, 1, 0, 0, 4'd0,  4'd9, 0, 1, 1);
        add(0, 0, 0, 1, 0, 4'd0,  4'd0, 0, 1, 1);
        add(0, 0, 0, 0, 1, 4'd0,  4'd0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 4'd0,  4'd0, 0, 1, 1);
        add(0, 1, 1, 0, 0, 4'd0,  4'd1, 0, 1, 0);
        add(1, 1, 1, 0, 0, 4'd0,  4'd0, 0, 0, 0);
`endif

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset held several cycles with CE high, then count on the first free edge
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 0, 4'd0);
            chk("hold_rst_o", 32'(o), 32'd0);
        end
        drive(0, 1, 1, 0, 0, 4'd0);
        chk("post_rst_o", 32'(o), 32'd1);
        drive(0, 1, 0, 0, 0, 4'd0);
        chk("down_o", 32'(o), 32'd0);

        // TC follows UP with no clock edge in between
        @(negedge clk);
        ce = 1'b0; up = 1'b0;
        #1 chk("tc_comb_dn", 32'(tc), 32'd1);
        up = 1'b1;
        #1 chk("tc_comb_up", 32'(tc), 32'd0);
        chk("tc_comb_o", 32'(o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
